// File: rtl/ppi_pkg.sv
// Shared constants for the ppi_hs parallel peripheral interface.
package ppi_pkg;

    // Host address map
    localparam logic [1:0] ADDR_PA   = 2'b00;
    localparam logic [1:0] ADDR_PB   = 2'b01;
    localparam logic [1:0] ADDR_PC   = 2'b10;
    localparam logic [1:0] ADDR_CTRL = 2'b11;

    // Control-word bit positions
    localparam int CW_MODESET   = 7;
    localparam int CW_A_MODE_HI = 6;
    localparam int CW_A_MODE_LO = 5;
    localparam int CW_A_DIR     = 4;
    localparam int CW_CU_DIR    = 3;
    localparam int CW_B_MODE    = 2;
    localparam int CW_B_DIR     = 1;
    localparam int CW_CL_DIR    = 0;

    // Port A two-bit mode field value selecting strobed mode
    localparam logic [1:0] A_MODE1_CODE = 2'b01;

    typedef enum logic {
        PM_MODE0 = 1'b0,
        PM_MODE1 = 1'b1
    } port_mode_e;

    // BSR indices that address the interrupt enables
    localparam logic [5:0] BSR_INTE_A = 6'd62;
    localparam logic [5:0] BSR_INTE_B = 6'd63;

    // Status byte layout
    localparam int ST_IBF_A  = 0;
    localparam int ST_OBF_A  = 1;
    localparam int ST_INTE_A = 2;
    localparam int ST_INTR_A = 3;
    localparam int ST_IBF_B  = 4;
    localparam int ST_OBF_B  = 5;
    localparam int ST_INTE_B = 6;
    localparam int ST_INTR_B = 7;

endpackage

// File: rtl/ppi_hs_port.sv
// One handshake-capable port: data latch, mode/direction, STB/ACK edge
// detection and the IBF / OBF_N / INTE / INTR flags.
module ppi_hs_port
    import ppi_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mode_set,
    input  logic         set_mode1,
    input  logic         set_dir_in,
    input  logic         wr_port,
    input  logic         rd_port,
    input  logic         inte_wr,
    input  logic         inte_val,
    input  logic         stb_n,
    input  logic         ack_n,
    input  logic [W-1:0] din,
    input  logic [W-1:0] pin_in,
    output logic [W-1:0] rd_data,
    output logic [W-1:0] pin_out,
    output logic         oe,
    output logic         ibf,
    output logic         obf_n,
    output logic         inte,
    output logic         intr
);

    port_mode_e   mode;
    logic         dir_in;
    logic [W-1:0] latch;
    logic         stb_q;
    logic         ack_q;

    logic m1_in, m1_out;
    logic stb_fall, stb_rise, ack_fall, ack_rise;

    assign m1_in    = (mode == PM_MODE1) &&  dir_in;
    assign m1_out   = (mode == PM_MODE1) && !dir_in;
    assign stb_fall =  stb_q && !stb_n;
    assign stb_rise = !stb_q &&  stb_n;
    assign ack_fall =  ack_q && !ack_n;
    assign ack_rise = !ack_q &&  ack_n;

    // Mode-0 input reads see live pins; every other case returns the latch
    assign rd_data = (mode == PM_MODE0 && dir_in) ? pin_in : latch;
    assign pin_out = latch;
    assign oe      = !dir_in;

    // Port state: mode-set has top priority, then host accesses and handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= PM_MODE0;
            dir_in <= 1'b1;
            latch  <= '0;
            stb_q  <= 1'b1;
            ack_q  <= 1'b1;
            ibf    <= 1'b0;
            obf_n  <= 1'b1;
            inte   <= 1'b0;
            intr   <= 1'b0;
        end else begin
            stb_q <= stb_n;
            ack_q <= ack_n;
            if (mode_set) begin
                mode   <= set_mode1 ? PM_MODE1 : PM_MODE0;
                dir_in <= set_dir_in;
                latch  <= '0;
                ibf    <= 1'b0;
                obf_n  <= 1'b1;
                inte   <= 1'b0;
                intr   <= 1'b0;
            end else begin
                if (inte_wr)
                    inte <= inte_val;
                if (m1_in) begin
                    // A strobe arriving while the buffer is full is dropped
                    if (stb_fall && !ibf) begin
                        latch <= pin_in;
                        ibf   <= 1'b1;
                    end else if (rd_port) begin
                        ibf <= 1'b0;
                    end
                    if (rd_port)
                        intr <= 1'b0;
                    else if (stb_rise && ibf && inte)
                        intr <= 1'b1;
                end else if (wr_port) begin
                    latch <= din;
                end
                if (m1_out) begin
                    if (wr_port)
                        obf_n <= 1'b0;
                    else if (ack_fall)
                        obf_n <= 1'b1;
                    if (wr_port)
                        intr <= 1'b0;
                    else if (ack_rise && inte)
                        intr <= 1'b1;
                end
                // Disabling the interrupt also retracts a pending request
                if (inte_wr && !inte_val)
                    intr <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ppi_hs.sv
// Synchronous 8255-style parallel interface: bus decode, port C and the
// host read mux; ports A and B are ppi_hs_port instances.
module ppi_hs
    import ppi_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         CS_N,
    input  logic         RD_N,
    input  logic         WR_N,
    input  logic [1:0]   A,
    input  logic [W-1:0] DIN,
    output logic [W-1:0] DOUT,
    output logic         DOE,
    input  logic [W-1:0] PA_IN,
    input  logic [W-1:0] PB_IN,
    input  logic [W-1:0] PC_IN,
    output logic [W-1:0] PA_OUT,
    output logic [W-1:0] PB_OUT,
    output logic [W-1:0] PC_OUT,
    output logic         PA_OE,
    output logic         PB_OE,
    output logic [W-1:0] PC_OE,
    input  logic         STB_N_A,
    input  logic         STB_N_B,
    input  logic         ACK_N_A,
    input  logic         ACK_N_B,
    output logic         IBF_A,
    output logic         IBF_B,
    output logic         OBF_N_A,
    output logic         OBF_N_B,
    output logic         INTR_A,
    output logic         INTR_B
);

    logic         acc_wr, acc_rd, ctrl_wr, mode_set, bsr;
    logic [5:0]   bsr_idx;
    logic [W-1:0] pa_rd, pb_rd, pc_rd;
    logic         inte_a, inte_b;
    logic         cu_in, cl_in;
    logic [W-1:0] pc_latch;
    logic [7:0]   status;

    assign acc_wr   = !CS_N && !WR_N;
    assign acc_rd   = !CS_N && !RD_N && WR_N;
    assign ctrl_wr  = acc_wr && (A == ADDR_CTRL);
    assign mode_set = ctrl_wr &&  DIN[CW_MODESET];
    assign bsr      = ctrl_wr && !DIN[CW_MODESET];
    assign bsr_idx  = DIN[6:1];

    ppi_hs_port #(.W(W)) u_port_a (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .mode_set   (mode_set),
        .set_mode1  (DIN[CW_A_MODE_HI:CW_A_MODE_LO] == A_MODE1_CODE),
        .set_dir_in (DIN[CW_A_DIR]),
        .wr_port    (acc_wr && (A == ADDR_PA)),
        .rd_port    (acc_rd && (A == ADDR_PA)),
        .inte_wr    (bsr && (bsr_idx == BSR_INTE_A)),
        .inte_val   (DIN[0]),
        .stb_n      (STB_N_A),
        .ack_n      (ACK_N_A),
        .din        (DIN),
        .pin_in     (PA_IN),
        .rd_data    (pa_rd),
        .pin_out    (PA_OUT),
        .oe         (PA_OE),
        .ibf        (IBF_A),
        .obf_n      (OBF_N_A),
        .inte       (inte_a),
        .intr       (INTR_A)
    );

    ppi_hs_port #(.W(W)) u_port_b (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .mode_set   (mode_set),
        .set_mode1  (DIN[CW_B_MODE]),
        .set_dir_in (DIN[CW_B_DIR]),
        .wr_port    (acc_wr && (A == ADDR_PB)),
        .rd_port    (acc_rd && (A == ADDR_PB)),
        .inte_wr    (bsr && (bsr_idx == BSR_INTE_B)),
        .inte_val   (DIN[0]),
        .stb_n      (STB_N_B),
        .ack_n      (ACK_N_B),
        .din        (DIN),
        .pin_in     (PB_IN),
        .rd_data    (pb_rd),
        .pin_out    (PB_OUT),
        .oe         (PB_OE),
        .ibf        (IBF_B),
        .obf_n      (OBF_N_B),
        .inte       (inte_b),
        .intr       (INTR_B)
    );

    // Port C latch and half-port directions; BSR touches one latch bit
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_latch <= '0;
            cu_in    <= 1'b1;
            cl_in    <= 1'b1;
        end else if (mode_set) begin
            pc_latch <= '0;
            cu_in    <= DIN[CW_CU_DIR];
            cl_in    <= DIN[CW_CL_DIR];
        end else if (acc_wr && (A == ADDR_PC)) begin
            pc_latch <= DIN;
        end else if (bsr) begin
            for (int i = 0; i < W; i++)
                if (bsr_idx == 6'(i))
                    pc_latch[i] <= DIN[0];
        end
    end

    assign PC_OUT = pc_latch;
    assign PC_OE  = {{(W/2){!cu_in}}, {(W/2){!cl_in}}};
    assign pc_rd  = (pc_latch & PC_OE) | (PC_IN & ~PC_OE);

    always_comb begin
        status            = '0;
        status[ST_IBF_A]  = IBF_A;
        status[ST_OBF_A]  = !OBF_N_A;
        status[ST_INTE_A] = inte_a;
        status[ST_INTR_A] = INTR_A;
        status[ST_IBF_B]  = IBF_B;
        status[ST_OBF_B]  = !OBF_N_B;
        status[ST_INTE_B] = inte_b;
        status[ST_INTR_B] = INTR_B;
    end

    // Host read mux: drives only while a read is being accepted
    always_comb begin
        DOUT = '0;
        DOE  = acc_rd;
        if (acc_rd) begin
            case (A)
                ADDR_PA: DOUT = pa_rd;
                ADDR_PB: DOUT = pb_rd;
                ADDR_PC: DOUT = pc_rd;
                default: DOUT = W'(status);
            endcase
        end
    end

endmodule

// File: tb/tb_ppi_hs.sv
// Directed self-checking bench for ppi_hs.
module tb_ppi_hs;
    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RESET_N = 1'b0;
    logic         CS_N = 1'b1, RD_N = 1'b1, WR_N = 1'b1;
    logic [1:0]   A = 2'b00;
    logic [W-1:0] DIN = '0;
    logic [W-1:0] DOUT;
    logic         DOE;
    logic [W-1:0] PA_IN = '0, PB_IN = '0, PC_IN = '0;
    logic [W-1:0] PA_OUT, PB_OUT, PC_OUT, PC_OE;
    logic         PA_OE, PB_OE;
    logic         STB_N_A = 1'b1, STB_N_B = 1'b1, ACK_N_A = 1'b1, ACK_N_B = 1'b1;
    logic         IBF_A, IBF_B, OBF_N_A, OBF_N_B, INTR_A, INTR_B;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] rd_val;
    logic         rd_oe;

    ppi_hs #(.W(W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N),
        .A(A), .DIN(DIN), .DOUT(DOUT), .DOE(DOE),
        .PA_IN(PA_IN), .PB_IN(PB_IN), .PC_IN(PC_IN),
        .PA_OUT(PA_OUT), .PB_OUT(PB_OUT), .PC_OUT(PC_OUT),
        .PA_OE(PA_OE), .PB_OE(PB_OE), .PC_OE(PC_OE),
        .STB_N_A(STB_N_A), .STB_N_B(STB_N_B), .ACK_N_A(ACK_N_A), .ACK_N_B(ACK_N_B),
        .IBF_A(IBF_A), .IBF_B(IBF_B), .OBF_N_A(OBF_N_A), .OBF_N_B(OBF_N_B),
        .INTR_A(INTR_A), .INTR_B(INTR_B)
    );

    always #5 CLK = ~CLK;

    task automatic bus_write(input logic [1:0] addr, input logic [W-1:0] data, input logic cs_n);
        @(negedge CLK);
        CS_N = cs_n; WR_N = 1'b0; RD_N = 1'b1; A = addr; DIN = data;
        @(negedge CLK);
        CS_N = 1'b1; WR_N = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [W-1:0] val, output logic oe);
        @(negedge CLK);
        CS_N = 1'b0; RD_N = 1'b0; WR_N = 1'b1; A = addr;
        #1;
        val = DOUT; oe = DOE;
        @(negedge CLK);
        CS_N = 1'b1; RD_N = 1'b1;
    endtask

    task automatic pulse_stb_a();
        @(negedge CLK); STB_N_A = 1'b0;
        @(negedge CLK); STB_N_A = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (PA_OE !== 1'b0) begin errors++; $display("FAIL reset_pa_oe got %b want 0", PA_OE); end
        checks++; if (PC_OE !== 8'h00) begin errors++; $display("FAIL reset_pc_oe got %h want 00", PC_OE); end
        checks++; if (DOE !== 1'b0 || DOUT !== 8'h00) begin errors++; $display("FAIL reset_bus got %b/%h want 0/00", DOE, DOUT); end
        checks++; if ({IBF_A, OBF_N_A, INTR_A, IBF_B, OBF_N_B, INTR_B} !== 6'b010_010) begin
            errors++; $display("FAIL reset_flags got %b want 010010", {IBF_A, OBF_N_A, INTR_A, IBF_B, OBF_N_B, INTR_B}); end
        RESET_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_mode0_out();
        bus_write(2'b11, 8'h80, 1'b0);
        bus_write(2'b00, 8'hA5, 1'b0);
        bus_write(2'b01, 8'h3C, 1'b0);
        bus_write(2'b10, 8'hFF, 1'b0);
        checks++; if (PA_OUT !== 8'hA5) begin errors++; $display("FAIL m0_pa_out got %h want A5", PA_OUT); end
        checks++; if (PB_OUT !== 8'h3C) begin errors++; $display("FAIL m0_pb_out got %h want 3C", PB_OUT); end
        checks++; if (PC_OUT !== 8'hFF) begin errors++; $display("FAIL m0_pc_out got %h want FF", PC_OUT); end
        checks++; if ({PA_OE, PB_OE, PC_OE} !== 10'h3FF) begin errors++; $display("FAIL m0_oe got %b%b%h want 11FF", PA_OE, PB_OE, PC_OE); end
        bus_read(2'b00, rd_val, rd_oe);
        checks++; if (rd_val !== 8'hA5 || rd_oe !== 1'b1) begin errors++; $display("FAIL m0_rd_a got %h/%b want A5/1", rd_val, rd_oe); end
        bus_read(2'b01, rd_val, rd_oe);
        checks++; if (rd_val !== 8'h3C) begin errors++; $display("FAIL m0_rd_b got %h want 3C", rd_val); end
        bus_read(2'b10, rd_val, rd_oe);
        checks++; if (rd_val !== 8'hFF) begin errors++; $display("FAIL m0_rd_c got %h want FF", rd_val); end
    endtask

    task automatic test_portc_input();
        bus_write(2'b11, 8'h89, 1'b0);
        PC_IN = 8'h5A;
        checks++; if (PC_OE !== 8'h00) begin errors++; $display("FAIL pc_in_oe got %h want 00", PC_OE); end
        bus_read(2'b10, rd_val, rd_oe);
        checks++; if (rd_val !== 8'h5A || rd_oe !== 1'b1) begin errors++; $display("FAIL pc_in_rd got %h/%b want 5A/1", rd_val, rd_oe); end
        #1;
        checks++; if (DOE !== 1'b0 || DOUT !== 8'h00) begin errors++; $display("FAIL pc_idle_bus got %b/%h want 0/00", DOE, DOUT); end
        bus_write(2'b11, 8'h07, 1'b0);
        checks++; if (PC_OUT !== 8'h08) begin errors++; $display("FAIL bsr_set got %h want 08", PC_OUT); end
        bus_write(2'b11, 8'h06, 1'b0);
        checks++; if (PC_OUT !== 8'h00) begin errors++; $display("FAIL bsr_clr got %h want 00", PC_OUT); end
    endtask

    task automatic test_mode1_in();
        bus_write(2'b11, 8'hB0, 1'b0);
        bus_write(2'b11, 8'h7D, 1'b0);
        PA_IN = 8'h42;
        checks++; if (PA_OE !== 1'b0) begin errors++; $display("FAIL m1in_oe got %b want 0", PA_OE); end
        @(negedge CLK); STB_N_A = 1'b0;
        @(negedge CLK); STB_N_A = 1'b1;
        checks++; if (IBF_A !== 1'b1 || INTR_A !== 1'b0) begin errors++; $display("FAIL m1in_ibf got %b/%b want 1/0", IBF_A, INTR_A); end
        @(negedge CLK);
        checks++; if (INTR_A !== 1'b1) begin errors++; $display("FAIL m1in_intr got %b want 1", INTR_A); end
        bus_read(2'b11, rd_val, rd_oe);
        checks++; if (rd_val !== 8'h0D) begin errors++; $display("FAIL m1in_status got %h want 0D", rd_val); end
        PA_IN = 8'h00;
        bus_read(2'b00, rd_val, rd_oe);
        checks++; if (rd_val !== 8'h42) begin errors++; $display("FAIL m1in_rd got %h want 42", rd_val); end
        checks++; if (IBF_A !== 1'b0 || INTR_A !== 1'b0) begin errors++; $display("FAIL m1in_clr got %b/%b want 0/0", IBF_A, INTR_A); end
    endtask

    task automatic test_strobe_drop();
        bus_write(2'b11, 8'hB0, 1'b0);
        bus_write(2'b11, 8'h7D, 1'b0);
        PA_IN = 8'h42; pulse_stb_a();
        PA_IN = 8'h99; pulse_stb_a();
        @(negedge CLK);
        bus_read(2'b00, rd_val, rd_oe);
        checks++; if (rd_val !== 8'h42) begin errors++; $display("FAIL drop_rd got %h want 42", rd_val); end
        // Refill, then strobe and read in the same cycle while full
        PA_IN = 8'h11; pulse_stb_a();
        PA_IN = 8'h55;
        @(negedge CLK);
        CS_N = 1'b0; RD_N = 1'b0; A = 2'b00; STB_N_A = 1'b0;
        #1; rd_val = DOUT;
        @(negedge CLK);
        CS_N = 1'b1; RD_N = 1'b1; STB_N_A = 1'b1;
        checks++; if (rd_val !== 8'h11) begin errors++; $display("FAIL drop_same_rd got %h want 11", rd_val); end
        checks++; if (IBF_A !== 1'b0) begin errors++; $display("FAIL drop_same_ibf got %b want 0", IBF_A); end
    endtask

    task automatic test_mode1_out();
        bus_write(2'b11, 8'h84, 1'b0);
        bus_write(2'b11, 8'h7F, 1'b0);
        bus_write(2'b01, 8'h77, 1'b0);
        checks++; if (OBF_N_B !== 1'b0 || PB_OUT !== 8'h77 || PB_OE !== 1'b1) begin
            errors++; $display("FAIL m1out_wr got %b/%h/%b want 0/77/1", OBF_N_B, PB_OUT, PB_OE); end
        @(negedge CLK); ACK_N_B = 1'b0;
        @(negedge CLK); ACK_N_B = 1'b1;
        checks++; if (OBF_N_B !== 1'b1 || INTR_B !== 1'b0) begin errors++; $display("FAIL m1out_ack got %b/%b want 1/0", OBF_N_B, INTR_B); end
        @(negedge CLK);
        checks++; if (INTR_B !== 1'b1) begin errors++; $display("FAIL m1out_intr got %b want 1", INTR_B); end
        bus_read(2'b11, rd_val, rd_oe);
        checks++; if (rd_val !== 8'hC0) begin errors++; $display("FAIL m1out_status got %h want C0", rd_val); end
        bus_write(2'b11, 8'h7E, 1'b0);
        checks++; if (INTR_B !== 1'b0) begin errors++; $display("FAIL inte_clr_intr got %b want 0", INTR_B); end
    endtask

    task automatic test_reset_mid();
        bus_write(2'b11, 8'hB0, 1'b0);
        PA_IN = 8'h3E; pulse_stb_a();
        checks++; if (IBF_A !== 1'b1) begin errors++; $display("FAIL mid_ibf_pre got %b want 1", IBF_A); end
        #2 RESET_N = 1'b0;
        #1;
        checks++; if (IBF_A !== 1'b0 || PA_OUT !== 8'h00 || OBF_N_B !== 1'b1) begin
            errors++; $display("FAIL mid_reset got %b/%h/%b want 0/00/1", IBF_A, PA_OUT, OBF_N_B); end
        @(negedge CLK); RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (IBF_A !== 1'b0) begin errors++; $display("FAIL mid_spurious got %b want 0", IBF_A); end
        bus_write(2'b11, 8'h80, 1'b1);
        bus_write(2'b10, 8'hC3, 1'b1);
        checks++; if (PA_OE !== 1'b0 || PC_OE !== 8'h00 || PC_OUT !== 8'h00) begin
            errors++; $display("FAIL cs_gate got %b/%h/%h want 0/00/00", PA_OE, PC_OE, PC_OUT); end
    endtask

    initial begin
        test_reset();
        test_mode0_out();
        test_portc_input();
        test_mode1_in();
        test_strobe_drop();
        test_mode1_out();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ppi_hs.md
# ppi_hs

Synchronous, parametrised successor to the combinational 8255-style parallel peripheral interface. It provides two handshake-capable ports (A, B) and a split control/status port C, each W bits wide. Mode 1 is strobed I/O with IBF, OBF_N and INTR handshakes. The block sits between the host bus and the external pins; pin and bus tristating is done at the top level from the OE outputs.

## Interface
Parameters:
- W, 8, width of the data bus and of ports A, B and C; legal range 8..32, must be even.

Ports:
- CLK  in  1  single clock; every input is synchronous to it.
- RESET_N  in  1  asynchronous, active-low reset.
- CS_N, RD_N, WR_N  in  1 each  active-low chip select, read strobe and write strobe; the host asserts a strobe for exactly one cycle per access.
- A  in  2  address: 00 = port A, 01 = port B, 10 = port C, 11 = control (write) / status (read).
- DIN  in  W  host write data.
- DOUT  out  W  host read data.
- DOE  out  1  host bus drive enable.
- PA_IN, PB_IN, PC_IN  in  W each  pin inputs.
- PA_OUT, PB_OUT, PC_OUT  out  W each  pin output latches.
- PA_OE, PB_OE  out  1 each  whole-port drive enable.
- PC_OE  out  W  per-bit drive enable.
- STB_N_A, STB_N_B  in  1 each  mode-1 input strobes.
- ACK_N_A, ACK_N_B  in  1 each  mode-1 output acknowledges.
- IBF_A, IBF_B, OBF_N_A, OBF_N_B, INTR_A, INTR_B  out  1 each  handshake outputs.

## Operation
- Accesses:
  - Write is accepted in a cycle with CS_N=0, WR_N=0.
  - Read is accepted in a cycle with CS_N=0, RD_N=0, WR_N=1.
  - RD_N and WR_N both low: the write is accepted and DOE=0.
- Control write (A=11), mode-set (DIN[7]=1):
  - DIN[6:5] A mode: 01 = mode 1, any other value = mode 0. DIN[4] A direction, 1 = input.
  - DIN[3] C upper half direction (bits W-1..W/2). DIN[2] B mode, 1 = mode 1. DIN[1] B direction. DIN[0] C lower half direction.
  - Side effects: clears PA/PB/PC_OUT, IBF, INTR and INTE; sets OBF_N=1.
- Control write, BSR (DIN[7]=0): idx = DIN[6:1], val = DIN[0].
  - idx < W: PC_OUT[idx] = val.
  - idx = 62: INTE_A = val. idx = 63: INTE_B = val.
  - Any other idx: ignored.
  - BSR is legal in every mode.
- Mode 0:
  - Output port: OE=1, pins = latch, reads return the latch.
  - Input port: OE=0, reads return the live pins.
  - Writes to an input port update the latch without driving it.
- Port C: each half follows its own direction bit; PC_OE per bit; reads mix latch bits (output) and pin bits (input).
- Mode 1 input, port X:
  - OE=0.
  - STB_N_X falling edge (sampled 1 then 0): latch PX_IN, IBF_X=1.
  - Falling edge while IBF_X=1: dropped; latch and IBF unchanged.
  - STB_N_X rising edge with IBF_X & INTE_X: INTR_X=1.
  - Accepted read of port X: returns the latch, clears IBF_X and INTR_X.
- Mode 1 output, port X:
  - OE=1.
  - Accepted write: latch DIN, OBF_N_X=0, INTR_X=0.
  - ACK_N_X falling edge: OBF_N_X=1.
  - ACK_N_X rising edge with INTE_X: INTR_X=1.
- Status read (A=11), zeros above bit 7:
  - [0] IBF_A, [1] ~OBF_N_A, [2] INTE_A, [3] INTR_A.
  - [4] IBF_B, [5] ~OBF_N_B, [6] INTE_B, [7] INTR_B.
- Precedence:
  - Mode-set beats every handshake event in the same cycle.
  - Strobe falling edge and read in the same cycle with IBF=1: read returns the old data, clears IBF, and the strobe is dropped.
  - Host write and ACK falling edge in the same cycle: write wins, OBF_N=0.
  - Clearing INTE via BSR clears INTR in the same edge.

## Timing
- Reset (asynchronous, immediate):
  - All latches 0; all ports mode 0, input.
  - PA/PB_OE=0, PC_OE=0, DOE=0, DOUT=0.
  - IBF=0, OBF_N=1, INTR=0, INTE=0.
  - STB/ACK edge samplers preset to 1.
- Reset mid-handshake abandons it; no spurious edge is detected on release.
- Reads: DOUT and DOE are combinational from A, strobes and registers; zero latency.
- DOE=1 only while a read is accepted; DOUT=0 otherwise.
- Writes and handshake events update registers at the accepting CLK edge; pins, OE and flags show the new value in the next cycle.
- Edge detectors compare the current input with the value registered at the previous edge, so a one-cycle strobe pulse is sufficient.

## Structure
- Shared package ppi_pkg:
  - Address constants.
  - Control-word bit positions.
  - Mode encodings.
  - BSR INTE indices 62/63.
  - Status bit positions.
- Sub-module ppi_hs_port, instantiated for A and B, containing:
  - Data latch.
  - Mode/direction registers.
  - STB/ACK edge detectors.
  - IBF/OBF_N/INTE/INTR logic.
- Port C, the bus decode and the read mux live in ppi_hs.

## Test plan
- Reset then control write 0x80 (all mode-0 outputs), write A=0xA5, B=0x3C, C=0xFF -> PA_OUT=0xA5, PB_OUT=0x3C, PC_OUT=0xFF, all OE=1; read back matches.
- Control write 0x89 (C input, A/B output), PC_IN=0x5A, read C -> DOUT=0x5A, DOE=1 during the read only, PC_OE=0; BSR 0x07 then 0x06 -> PC_OUT[3] goes 1 then 0.
- Control write 0xB0 (A mode-1 input), BSR 0x7D (INTE_A=1), PA_IN=0x42, pulse STB_N_A -> IBF_A=1 next cycle, INTR_A=1 after the rising edge; read A -> 0x42, IBF_A=INTR_A=0.
- Same setup, second STB_N_A pulse with PA_IN=0x99 before the read -> read still returns 0x42.
- Control write 0x84 (B mode-1 output), BSR 0x7F, write B=0x77 -> OBF_N_B=0, PB_OUT=0x77; pulse ACK_N_B -> OBF_N_B=1, then INTR_B=1; status read bit 7 = 1.
- Assert RESET_N=0 mid-handshake with IBF_A=1 -> all outputs return to reset values immediately; CS_N=1 writes during a later test leave every register unchanged.
